// File: rtl/sync_filter_pkg.sv
// sync_filter_pkg: shared defaults and counter sizing for the sync filter
package sync_filter_pkg;

    localparam int DEF_STAGE      = 2;
    localparam int DEF_DATA_WIDTH = 1;
    localparam int DEF_FILT_CNT   = 4;

    // Counter must hold 0..n without wrapping
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sync_filter_ch.sv
// sync_filter_ch: per-channel stability counter, filtered level and edge pulses
module sync_filter_ch
    import sync_filter_pkg::*;
#(
    parameter int   FILT_CNT = DEF_FILT_CNT,
    parameter logic RST_BIT  = 1'b0
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic clr_i,
    input  logic syn_i,
    output logic dat_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CW = cnt_width(FILT_CNT);

    logic [CW-1:0] cnt;
    logic          hit;

    assign hit = (cnt == CW'(FILT_CNT - 1));

    // Filter state: restart the count on agreement, commit after FILT_CNT disagreeing cycles
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || clr_i) begin
            cnt    <= '0;
            dat_o  <= RST_BIT;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else if (!en_i) begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else if (syn_i == dat_o) begin
            cnt    <= '0;
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else if (hit) begin
            cnt    <= '0;
            dat_o  <= syn_i;
            rise_o <= syn_i;
            fall_o <= ~syn_i;
        end else begin
            cnt    <= cnt + CW'(1);
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end
    end

endmodule

// File: rtl/sync_filter.sv
// sync_filter: multi-channel synchroniser with stability filter and edge detect
module sync_filter
    import sync_filter_pkg::*;
#(
    parameter int                  STAGE      = DEF_STAGE,
    parameter int                  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                  FILT_CNT   = DEF_FILT_CNT,
    parameter logic [DATA_WIDTH-1:0] RST_VAL  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic [DATA_WIDTH-1:0] rise_o,
    output logic [DATA_WIDTH-1:0] fall_o,
    output logic [DATA_WIDTH-1:0] edge_o
);

    logic [DATA_WIDTH-1:0] sync_q [STAGE];

    // Plain flop chain; only reset touches it so metastability settles undisturbed
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < STAGE; i++) sync_q[i] <= RST_VAL;
        end else begin
            sync_q[0] <= dat_i;
            for (int i = 1; i < STAGE; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_ch
        sync_filter_ch #(
            .FILT_CNT (FILT_CNT),
            .RST_BIT  (RST_VAL[g])
        ) u_ch (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .en_i    (en_i),
            .clr_i   (clr_i),
            .syn_i   (sync_q[STAGE-1][g]),
            .dat_o   (dat_o[g]),
            .rise_o  (rise_o[g]),
            .fall_o  (fall_o[g])
        );
    end

    assign edge_o = rise_o | fall_o;

endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: directed checks of the sync filter with STAGE=2, FILT_CNT=4, 4 channels
module tb_sync_filter;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       en_i;
    logic       clr_i;
    logic [3:0] dat_i;
    logic [3:0] dat_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic [3:0] edge_o;

    int n_vec = 0;
    int n_err = 0;

    sync_filter #(
        .STAGE      (2),
        .DATA_WIDTH (4),
        .FILT_CNT   (4),
        .RST_VAL    (4'h0)
    ) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (en_i),
        .clr_i   (clr_i),
        .dat_i   (dat_i),
        .dat_o   (dat_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .edge_o  (edge_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        en_i    = 1'b1;
        clr_i   = 1'b0;
        dat_i   = 4'hF;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if (dat_o !== 4'h0) begin n_err++; $display("FAIL reset_dat k=%0d: got %h want 0", k, dat_o); end
            n_vec++;
            if ({rise_o, fall_o, edge_o} !== 12'h000) begin n_err++; $display("FAIL reset_pulse k=%0d: got %h/%h/%h want 0/0/0", k, rise_o, fall_o, edge_o); end
        end
        dat_i   = 4'h0;
        rst_n_i = 1'b1;
        for (int k = 1; k <= 3; k++) tick();
        n_vec++;
        if (dat_o !== 4'h0) begin n_err++; $display("FAIL post_reset_dat: got %h want 0", dat_o); end
    endtask

    task automatic test_rise();
        dat_i = 4'h1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_vec++;
            if (dat_o !== ((k >= 6) ? 4'h1 : 4'h0)) begin n_err++; $display("FAIL rise_dat k=%0d: got %h want %h", k, dat_o, (k >= 6) ? 4'h1 : 4'h0); end
            n_vec++;
            if (rise_o !== ((k == 6) ? 4'h1 : 4'h0) || edge_o !== ((k == 6) ? 4'h1 : 4'h0) || fall_o !== 4'h0) begin
                n_err++; $display("FAIL rise_pulse k=%0d: got r%h f%h e%h", k, rise_o, fall_o, edge_o);
            end
        end
    endtask

    task automatic test_glitch();
        dat_i = 4'h3;
        for (int k = 1; k <= 10; k++) begin
            if (k == 4) dat_i = 4'h1;
            tick();
            n_vec++;
            if (dat_o !== 4'h1) begin n_err++; $display("FAIL glitch_dat k=%0d: got %h want 1", k, dat_o); end
            n_vec++;
            if (edge_o !== 4'h0 || rise_o !== 4'h0 || fall_o !== 4'h0) begin n_err++; $display("FAIL glitch_pulse k=%0d: got r%h f%h e%h want 0", k, rise_o, fall_o, edge_o); end
        end
    endtask

    task automatic test_enable();
        dat_i = 4'h5;
        for (int k = 1; k <= 12; k++) begin
            en_i = (k >= 5 && k <= 9) ? 1'b0 : 1'b1;
            tick();
            n_vec++;
            if (dat_o !== ((k >= 11) ? 4'h5 : 4'h1)) begin n_err++; $display("FAIL enable_dat k=%0d: got %h want %h", k, dat_o, (k >= 11) ? 4'h5 : 4'h1); end
            n_vec++;
            if (rise_o !== ((k == 11) ? 4'h4 : 4'h0) || fall_o !== 4'h0) begin n_err++; $display("FAIL enable_pulse k=%0d: got r%h f%h", k, rise_o, fall_o); end
        end
        en_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        dat_i = 4'hF;
        for (int k = 1; k <= 6; k++) tick();
        n_vec++;
        if (dat_o !== 4'hF || rise_o !== 4'hA) begin n_err++; $display("FAIL all_high: got d%h r%h want dF rA", dat_o, rise_o); end
        dat_i = 4'h0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_vec++;
            if (dat_o !== ((k >= 6) ? 4'h0 : 4'hF)) begin n_err++; $display("FAIL fall_dat k=%0d: got %h want %h", k, dat_o, (k >= 6) ? 4'h0 : 4'hF); end
            n_vec++;
            if (fall_o !== ((k == 6) ? 4'hF : 4'h0) || edge_o !== ((k == 6) ? 4'hF : 4'h0) || rise_o !== 4'h0) begin
                n_err++; $display("FAIL fall_pulse k=%0d: got r%h f%h e%h", k, rise_o, fall_o, edge_o);
            end
        end
    endtask

    task automatic test_clear();
        dat_i = 4'hF;
        for (int k = 1; k <= 6; k++) tick();
        n_vec++;
        if (dat_o !== 4'hF || rise_o !== 4'hF) begin n_err++; $display("FAIL clr_setup: got d%h r%h want dF rF", dat_o, rise_o); end
        dat_i = 4'h0;
        for (int k = 1; k <= 10; k++) begin
            clr_i = (k == 5);
            tick();
            n_vec++;
            if (dat_o !== ((k >= 5) ? 4'h0 : 4'hF)) begin n_err++; $display("FAIL clr_dat k=%0d: got %h want %h", k, dat_o, (k >= 5) ? 4'h0 : 4'hF); end
            n_vec++;
            if (edge_o !== 4'h0 || fall_o !== 4'h0 || rise_o !== 4'h0) begin n_err++; $display("FAIL clr_pulse k=%0d: got r%h f%h e%h want 0", k, rise_o, fall_o, edge_o); end
        end
        clr_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        dat_i = 4'h1;
        for (int k = 1; k <= 5; k++) tick();
        rst_n_i = 1'b0;
        tick();
        n_vec++;
        if (dat_o !== 4'h0 || edge_o !== 4'h0) begin n_err++; $display("FAIL midrst_dat: got d%h e%h want d0 e0", dat_o, edge_o); end
        rst_n_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_vec++;
            if (dat_o !== ((k >= 6) ? 4'h1 : 4'h0)) begin n_err++; $display("FAIL midrst_restart k=%0d: got %h want %h", k, dat_o, (k >= 6) ? 4'h1 : 4'h0); end
            n_vec++;
            if (rise_o !== ((k == 6) ? 4'h1 : 4'h0) || fall_o !== 4'h0) begin n_err++; $display("FAIL midrst_pulse k=%0d: got r%h f%h", k, rise_o, fall_o); end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_glitch();
        test_enable();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sync_filter.md
SYNC_FILTER -- requirements
Module: sync_filter

Interface
REQ-001 SHALL have parameter STAGE, default 2, synchroniser flop depth (legal >= 2).
REQ-002 SHALL have parameter DATA_WIDTH, default 1, number of independent channels.
REQ-003 SHALL have parameter FILT_CNT, default 4, consecutive stable cycles required before the output follows the input (legal >= 1).
REQ-004 SHALL have parameter RST_VAL, default '0, DATA_WIDTH-bit reset/clear level of the chain and outputs.
REQ-005 SHALL have port clk_i  input  1  sole clock.
REQ-006 SHALL have port rst_n_i  input  1  reset; synchronous, active-low.
REQ-007 SHALL have port en_i  input  1  filter enable; low = hold filter state.
REQ-008 SHALL have port clr_i  input  1  synchronous soft clear of filter state.
REQ-009 SHALL have port dat_i  input  DATA_WIDTH  asynchronous per-channel inputs.
REQ-010 SHALL have port dat_o  output  DATA_WIDTH  filtered, synchronised level.
REQ-011 SHALL have port rise_o  output  DATA_WIDTH  one-cycle pulse on dat_o 0->1.
REQ-012 SHALL have port fall_o  output  DATA_WIDTH  one-cycle pulse on dat_o 1->0.
REQ-013 SHALL have port edge_o  output  DATA_WIDTH  rise_o | fall_o.

Function
REQ-014 Each channel SHALL pass dat_i through STAGE flops in series; chain runs regardless of en_i and clr_i.
REQ-015 Each channel SHALL keep a counter of width $clog2(FILT_CNT+1), saturating, never wrapping.
REQ-016 With en_i=1: synced bit == dat_o -> counter cleared to 0, dat_o held.
REQ-017 With en_i=1: synced bit != dat_o and counter < FILT_CNT-1 -> counter increments.
REQ-018 With en_i=1: synced bit != dat_o and counter == FILT_CNT-1 -> dat_o takes synced bit at that edge, counter cleared.
REQ-019 Latency: an input step held stable, first sampled at edge 1, SHALL appear on dat_o after edge STAGE+FILT_CNT; FILT_CNT=1 gives a plain STAGE+1 delay.
REQ-020 Any input disagreement lasting fewer than FILT_CNT synced cycles SHALL leave dat_o unchanged and clear the counter on return.
REQ-021 rise_o/fall_o SHALL be registered, asserted exactly the cycle dat_o shows the new value, one cycle wide; no pulse without a dat_o change.
REQ-022 en_i=0 SHALL hold counters and dat_o; rise_o/fall_o/edge_o = 0.
REQ-023 clr_i=1 SHALL clear counters, load dat_o with RST_VAL, force pulses to 0 (no pulse from the clear itself).
REQ-024 Priority SHALL be rst_n_i over clr_i over en_i.
REQ-025 Channels SHALL be fully independent; simultaneous changes on several channels produce simultaneous per-channel pulses.

Reset
REQ-026 On rst_n_i=0 at a clk_i edge: chain flops and dat_o = RST_VAL, counters = 0, rise_o/fall_o/edge_o = 0.
REQ-027 Reset asserted mid-count SHALL discard the partial count; no pulse in the cycle after release.

Structure
REQ-028 Package sync_filter_pkg SHALL hold the counter-width function and default parameter constants.
REQ-029 Per-channel filter (counter + output flop + edge flops) SHALL be sub-module sync_filter_ch, instantiated DATA_WIDTH times via generate.
REQ-030 Synchroniser flops SHALL carry no logic between stages.

Verification (STAGE=2, FILT_CNT=4, DATA_WIDTH=4, RST_VAL=4'h0)
REQ-031 Reset held 3 cycles with dat_i=4'hF -> dat_o=0, rise_o=fall_o=edge_o=0 throughout.
REQ-032 dat_i[0] 0->1 before edge 1, held -> dat_o[0]=1 after edge 6; rise_o[0]=edge_o[0]=1 that cycle only.
REQ-033 dat_i[1] high for 3 cycles then low -> dat_o[1] stays 0, no pulses.
REQ-034 dat_i[2] step, en_i=0 for 5 cycles after 2 counted cycles -> dat_o[2] changes 5 cycles later than REQ-032 timing.
REQ-035 dat_o=4'hF, dat_i=4'h0 -> fall_o=4'hF in one cycle; repeat with clr_i pulse mid-count -> dat_o=0, no pulse.
REQ-036 rst_n_i low 1 cycle at counter=3 -> dat_o=RST_VAL, counting restarts from 0 after release.
